// File: rtl/playback_controller.sv
// Transport controller: button/song_done pulses -> play enable, song select, player restart, loop modes, beat-timed gap.
// Latency: every output registered, response one cycle after the sampled pulse; no backpressure (single-cycle pulse inputs).
module playback_controller #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_BITS = 2,
    parameter int GAP_BEATS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_play_button,
    input  logic                 i_next_button,
    input  logic                 i_prev_button,
    input  logic                 i_mode_button,
    input  logic                 i_song_done,
    input  logic                 i_beat,
    output logic                 o_play,
    output logic                 o_reset_player,
    output logic [SONG_BITS-1:0] o_current_song,
    output logic [1:0]           o_loop_mode,
    output logic [15:0]          o_beat_count,
    output logic                 o_in_gap
);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    localparam logic [1:0]           MODE_OFF = 2'd0;
    localparam logic [1:0]           MODE_ONE = 2'd1;
    localparam logic [1:0]           MODE_ALL = 2'd2;
    localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);
    localparam logic [7:0]           GAP_LEN   = 8'(GAP_BEATS);

    state_t               r_state, w_state_nxt;
    logic [SONG_BITS-1:0] r_song, w_song_nxt;
    logic [1:0]           r_mode, w_mode_nxt;
    logic                 r_reset_player, w_reset_player_nxt;
    logic [15:0]          r_beat_count, w_beat_count_nxt;
    logic [7:0]           r_gap_cnt, w_gap_cnt_nxt;
    logic [SONG_BITS-1:0] w_song_inc, w_song_dec;
    state_t               w_after_done;

    assign w_song_inc   = (r_song == LAST_SONG) ? '0 : r_song + 1'b1;
    assign w_song_dec   = (r_song == '0) ? LAST_SONG : r_song - 1'b1;
    // With a zero-length gap, auto-advance resumes playback directly.
    assign w_after_done = (GAP_LEN == 8'd0) ? ST_PLAYING : ST_GAP;

    always_comb begin
        w_state_nxt        = r_state;
        w_song_nxt         = r_song;
        w_reset_player_nxt = 1'b0;
        w_gap_cnt_nxt      = r_gap_cnt;

        if (i_next_button) begin
            w_song_nxt         = w_song_inc;
            w_reset_player_nxt = 1'b1;
            w_state_nxt        = ST_PAUSED;
        end else if (i_prev_button) begin
            w_song_nxt         = w_song_dec;
            w_reset_player_nxt = 1'b1;
            w_state_nxt        = ST_PAUSED;
        end else if (i_play_button) begin
            w_state_nxt = (r_state == ST_PAUSED) ? ST_PLAYING : ST_PAUSED;
        end else if (i_song_done && r_state == ST_PLAYING) begin
            w_reset_player_nxt = 1'b1;
            w_gap_cnt_nxt      = 8'd0;
            if (r_mode == MODE_ONE) begin
                w_state_nxt = w_after_done;
            end else if (r_mode == MODE_OFF && r_song == LAST_SONG) begin
                w_song_nxt  = '0;
                w_state_nxt = ST_PAUSED;
            end else begin
                w_song_nxt  = w_song_inc;
                w_state_nxt = w_after_done;
            end
        end else if (r_state == ST_GAP && i_beat) begin
            w_gap_cnt_nxt = r_gap_cnt + 8'd1;
            if (r_gap_cnt + 8'd1 == GAP_LEN) begin
                w_state_nxt = ST_PLAYING;
            end
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (i_mode_button) begin
            w_mode_nxt = (r_mode == MODE_OFF) ? MODE_ONE :
                         (r_mode == MODE_ONE) ? MODE_ALL : MODE_OFF;
        end
    end

    // A restart clears the count even when a beat lands in the same cycle.
    always_comb begin
        w_beat_count_nxt = r_beat_count;
        if (w_reset_player_nxt) begin
            w_beat_count_nxt = 16'd0;
        end else if (r_state == ST_PLAYING && i_beat && r_beat_count != 16'hFFFF) begin
            w_beat_count_nxt = r_beat_count + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_PAUSED;
            r_song         <= '0;
            r_mode         <= MODE_OFF;
            r_reset_player <= 1'b0;
            r_beat_count   <= 16'd0;
            r_gap_cnt      <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_song         <= w_song_nxt;
            r_mode         <= w_mode_nxt;
            r_reset_player <= w_reset_player_nxt;
            r_beat_count   <= w_beat_count_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
        end
    end

    assign o_play         = (r_state == ST_PLAYING);
    assign o_in_gap       = (r_state == ST_GAP);
    assign o_reset_player = r_reset_player;
    assign o_current_song = r_song;
    assign o_loop_mode    = r_mode;
    assign o_beat_count   = r_beat_count;

endmodule

// File: doc/playback_controller.md
# playback_controller

Parametrised transport controller for the music player: turns debounced single-cycle play/next/prev/mode button pulses and the song reader's song_done into play enable, song selection, and player restart. Generalises the two-button play/next control to NUM_SONGS songs, adds previous-song, three loop modes, an inter-song gap timed in beats, and an elapsed-beat counter. Sits between the button one-pulsers and the song reader / note player. Runs on the same clock as the AC97 sample path.

## Interface
- NUM_SONGS, 4, number of songs in song ROM; 2 ≤ NUM_SONGS ≤ 2^SONG_BITS
- SONG_BITS, 2, width of song index
- GAP_BEATS, 4, beat pulses of silence between auto-advanced songs; 0..255
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- play_button  input  1  one-cycle pulse: toggle play/pause
- next_button  input  1  one-cycle pulse: next song
- prev_button  input  1  one-cycle pulse: previous song
- mode_button  input  1  one-cycle pulse: cycle loop mode
- song_done  input  1  one-cycle pulse from song reader: current song finished
- beat  input  1  one-cycle beat tick (BEAT_COUNT-derived)
- play  output  1  enable to song reader / note player
- reset_player  output  1  one-cycle pulse restarting song reader at note 0
- current_song  output  SONG_BITS  selected song index
- loop_mode  output  2  0 OFF, 1 ONE, 2 ALL (3 never produced)
- beat_count  output  16  beats elapsed while playing in current song
- in_gap  output  1  high in GAP state

## Operation
- States: PAUSED, PLAYING, GAP. play = (state == PLAYING); in_gap = (state == GAP).
- Input priority per cycle: next > prev > play_button > song_done. mode_button acts independently, same cycle as any other.
- next_button (any state): current_song ← (current_song+1) mod NUM_SONGS; reset_player pulse; → PAUSED.
- prev_button (any state): current_song ← current_song−1, 0 wraps to NUM_SONGS−1; reset_player pulse; → PAUSED.
- play_button: PAUSED → PLAYING; PLAYING → PAUSED; GAP → PAUSED (gap abandoned; song already selected, no second reset_player).
- song_done, honoured only in PLAYING (ignored in PAUSED/GAP):
  - OFF, song < NUM_SONGS−1: song+1, reset_player, → GAP.
  - OFF, last song: song ← 0, reset_player, → PAUSED.
  - ONE: song unchanged, reset_player, → GAP.
  - ALL: song+1 mod NUM_SONGS, reset_player, → GAP.
- GAP: 8-bit counter loaded 0 on entry; increments on beat; → PLAYING on the beat that makes it GAP_BEATS. GAP_BEATS = 0: song_done transitions go straight to PLAYING (GAP never entered).
- mode_button: loop_mode OFF→ONE→ALL→OFF.
- beat_count: +1 on beat while PLAYING, saturates at 16'hFFFF; cleared whenever reset_player is asserted; held in PAUSED/GAP.

## Timing
- All outputs registered; every response appears the cycle after the input pulse is sampled at posedge.
- reset_player high exactly one cycle, same cycle current_song shows the new value.
- Async reset: state PAUSED, current_song 0, loop_mode 0, play 0, reset_player 0, beat_count 0, in_gap 0, gap counter 0; takes effect immediately, mid-song or mid-gap, no pulse emitted on release.
- beat coinciding with song_done: beat counted into beat_count before clear loses (clear wins, beat_count = 0).
- beat coinciding with GAP entry is not counted toward the gap.
- beat coinciding with next/prev/play_button in GAP: button wins, no PLAYING transition.

## Test plan
- Reset, play_button, 3 beats, play_button → play 1 from cycle after press, beat_count 3, then play 0, beat_count held at 3.
- NUM_SONGS=4: next ×5 from song 0 → songs 1,2,3,0,1, each with one-cycle reset_player, play 0; prev from 0 → 3.
- Mode ALL, GAP_BEATS=4, playing song 3, song_done → song 0, reset_player, in_gap 1, play 0 for exactly 4 beats, play 1 the cycle after 4th beat.
- Mode OFF, song 3 song_done → song 0, PAUSED, no gap; mode ONE, song 2 song_done → song stays 2, reset_player, gap then replay.
- Simultaneous next + play_button + song_done in PLAYING on song 1 → song 2, one reset_player, PAUSED; song_done in PAUSED → no change.
- Assert reset mid-GAP at beat 2 → all outputs to reset values immediately; after release play_button → PLAYING song 0, loop_mode OFF.
